// File: rtl/csa_pkg.sv
// Shared widths and collector state encoding for the carry-save adder front-end.
package csa_pkg;
  localparam int CSA_WIDTH     = 16;
  localparam int CSA_SUM_WIDTH = CSA_WIDTH + 2;

  typedef enum logic [1:0] {
    COLLECT0 = 2'd0,
    COLLECT1 = 2'd1,
    COLLECT2 = 2'd2
  } cnt_t;
endpackage

// File: rtl/carry_save_adder.sv
// 3-operand adder: one 3:2 compression layer followed by a 17-bit ripple carry stage.
module carry_save_adder
  import csa_pkg::*;
(
  input  logic [CSA_WIDTH-1:0] a,
  input  logic [CSA_WIDTH-1:0] b,
  input  logic [CSA_WIDTH-1:0] c,
  output logic [CSA_WIDTH:0]   sum_final,
  output logic                 c_out_16
);
  logic [CSA_WIDTH-1:0] s_vec;
  logic [CSA_WIDTH-1:0] k_vec;
  logic [CSA_WIDTH:0]   x_vec;
  logic [CSA_WIDTH:0]   y_vec;
  logic [CSA_WIDTH+1:0] carry;

  assign s_vec = a ^ b ^ c;
  assign k_vec = (a & b) | (a & c) | (b & c);
  // Carry vector has weight 2, so it enters the ripple shifted up one place.
  assign x_vec = {1'b0, s_vec};
  assign y_vec = {k_vec, 1'b0};
  assign carry[0] = 1'b0;

  for (genvar gi = 0; gi <= CSA_WIDTH; gi++) begin : g_ripple
    assign sum_final[gi] = x_vec[gi] ^ y_vec[gi] ^ carry[gi];
    assign carry[gi+1]   = (x_vec[gi] & y_vec[gi]) | (x_vec[gi] & carry[gi]) |
                           (y_vec[gi] & carry[gi]);
  end

  assign c_out_16 = carry[CSA_WIDTH+1];
endmodule

// File: rtl/csa_operand_collector.sv
// Packs a 16-bit operand stream into groups of up to three and emits each group's
// registered exact sum on a valid/ready output.
module csa_operand_collector
  import csa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CSA_SUM_WIDTH-1:0] out_sum,
  output logic [1:0]               out_count
);
  if (WIDTH != CSA_WIDTH) begin : g_width_check
    $error("csa_operand_collector: WIDTH must be %0d", CSA_WIDTH);
  end

  cnt_t                     cnt_reg, cnt_next;
  logic [CSA_WIDTH-1:0]     op_a_reg, op_b_reg, op_c_reg;
  logic [CSA_SUM_WIDTH-1:0] out_sum_reg;
  logic [1:0]               out_count_reg;
  logic                     out_valid_reg;

  logic                     accept;
  logic                     complete;
  logic [CSA_WIDTH-1:0]     add_a, add_b, add_c;
  logic [CSA_WIDTH:0]       add_sum;
  logic                     add_carry;

  assign in_ready = !(out_valid_reg && !out_ready);
  assign accept   = in_valid && in_ready;
  assign complete = accept && (cnt_reg == COLLECT2 || in_last);

  // The live beat feeds the adder directly so the result lands one edge after it.
  always_comb begin
    add_a = op_a_reg;
    add_b = op_b_reg;
    add_c = '0;
    case (cnt_reg)
      COLLECT0: begin
        add_a = in_data;
        add_b = '0;
      end
      COLLECT1: add_b = in_data;
      COLLECT2: add_c = in_data;
      default: ;
    endcase
  end

  carry_save_adder u_adder (
    .a         (add_a),
    .b         (add_b),
    .c         (add_c),
    .sum_final (add_sum),
    .c_out_16  (add_carry)
  );

  always_comb begin
    cnt_next = cnt_reg;
    if (complete) begin
      cnt_next = COLLECT0;
    end else if (accept) begin
      case (cnt_reg)
        COLLECT0: cnt_next = COLLECT1;
        COLLECT1: cnt_next = COLLECT2;
        default:  cnt_next = COLLECT0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_reg <= COLLECT0;
    else     cnt_reg <= cnt_next;
  end

  always_ff @(posedge clk) begin
    if (rst || complete) begin
      op_a_reg <= '0;
      op_b_reg <= '0;
      op_c_reg <= '0;
    end else if (accept) begin
      case (cnt_reg)
        COLLECT0: op_a_reg <= in_data;
        COLLECT1: op_b_reg <= in_data;
        default:  op_c_reg <= in_data;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_sum_reg   <= '0;
      out_count_reg <= '0;
      out_valid_reg <= 1'b0;
    end else if (complete) begin
      out_sum_reg   <= {add_carry, add_sum};
      out_count_reg <= 2'(cnt_reg) + 2'd1;
      out_valid_reg <= 1'b1;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_sum   = out_sum_reg;
  assign out_count = out_count_reg;
  assign out_valid = out_valid_reg;
endmodule
